// File: rtl/median_filter_pkg.sv
// -----------------------------------------------------------------------------
// median_filter_pkg
// Shared types and helpers for the 3x3 median filter.
//   state_t   : frame-tracking state (IDLE, RUN)
//   PIPE_LAT  : edges from the completing pixel to registered outputs
//   lt()      : pixel less-than compare; its signedness is chosen at build time.
// Build option: MEDIAN_FILTER_SIGNED_EN selects two's-complement compares.
// -----------------------------------------------------------------------------
package median_filter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PIPE_LAT = 3;

    // lt() works on a wide zero-extended container so a single function can
    // serve every pixel width; callers pass their real width in dw.
    localparam int CMP_W = 64;

`ifdef MEDIAN_FILTER_SIGNED_EN
    localparam bit SIGNED_CMP = 1'b1;
`else
    localparam bit SIGNED_CMP = 1'b0;
`endif

    // A signed compare of dw-bit values equals an unsigned compare after
    // flipping bit dw-1 of both operands.
    function automatic logic lt(input logic [CMP_W-1:0] a,
                                input logic [CMP_W-1:0] b,
                                input int               dw);
        logic [CMP_W-1:0] flip;
        flip = (CMP_W'(1) << (dw - 1)) & {CMP_W{SIGNED_CMP}};
        return (a ^ flip) < (b ^ flip);
    endfunction

endpackage

// File: rtl/median_filter_3x3_if.sv
// -----------------------------------------------------------------------------
// median_filter_3x3_if
// Pixel stream in / window statistics out for median_filter_3x3.
//   in_valid, in_sof, in_data          : raster pixel beat
//   out_valid, out_sof                 : one pulse per interior window
//   out_med, out_min, out_max          : window rank results
//   frame_err                          : in_sof seen mid-frame
// master = pixel source side, slave = filter side.
// -----------------------------------------------------------------------------
interface median_filter_3x3_if #(parameter int DW = 16);

    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_sof;
    logic [DW-1:0] out_med;
    logic [DW-1:0] out_min;
    logic [DW-1:0] out_max;
    logic          frame_err;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_valid, out_sof, out_med, out_min, out_max, frame_err
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_valid, out_sof, out_med, out_min, out_max, frame_err
    );

endinterface

// File: rtl/median_filter_3x3_sort3_stage.sv
// -----------------------------------------------------------------------------
// sort3_stage
// Registered 3-input sorter. Data registers load only when in_vld is high, so
// the outputs hold their last result between valid beats.
//   clk, rst_n     : clock, synchronous active-low reset
//   in_vld         : qualifies a/b/c; passed through as out_vld (1 cycle later)
//   a, b, c        : unsorted inputs
//   lo, mid, hi    : sorted outputs (registered)
// Compare signedness follows MEDIAN_FILTER_SIGNED_EN through lt().
// -----------------------------------------------------------------------------
module sort3_stage
    import median_filter_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    output logic          out_vld,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] mid,
    output logic [DW-1:0] hi
);

    logic          vld_q;
    logic [DW-1:0] lo_q, mid_q, hi_q;
    logic [DW-1:0] lo_d, mid_d, hi_d;

    // Three compare-exchange steps: (0,1), (1,2), (0,1).
    always_comb begin
        logic [DW-1:0] x0, x1, x2, t;
        x0 = a;
        x1 = b;
        x2 = c;
        t  = '0;
        if (lt(CMP_W'(x1), CMP_W'(x0), DW)) begin t = x0; x0 = x1; x1 = t; end
        if (lt(CMP_W'(x2), CMP_W'(x1), DW)) begin t = x1; x1 = x2; x2 = t; end
        if (lt(CMP_W'(x1), CMP_W'(x0), DW)) begin t = x0; x0 = x1; x1 = t; end
        lo_d  = lo_q;
        mid_d = mid_q;
        hi_d  = hi_q;
        if (in_vld) begin
            lo_d  = x0;
            mid_d = x1;
            hi_d  = x2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            lo_q  <= '0;
            mid_q <= '0;
            hi_q  <= '0;
        end else begin
            vld_q <= in_vld;
            lo_q  <= lo_d;
            mid_q <= mid_d;
            hi_q  <= hi_d;
        end
    end

    assign out_vld = vld_q;
    assign lo      = lo_q;
    assign mid     = mid_q;
    assign hi      = hi_q;

endmodule

// File: rtl/median_filter_3x3.sv
// -----------------------------------------------------------------------------
// median_filter_3x3
// Streaming 3x3 rank filter: two line buffers feed a sliding 3x3 window whose
// median, minimum and maximum come out through a fixed 3-stage pipeline.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : median_filter_3x3_if.slave (pixel in, results out, frame_err)
// Parameters: DW pixel bits, IMG_W pixels per line, IMG_H lines per frame.
// Build option: MEDIAN_FILTER_SIGNED_EN makes every compare two's complement.
// Latency: pixel completing a window sampled at edge k -> outputs at edge k+3.
// -----------------------------------------------------------------------------
module median_filter_3x3
    import median_filter_pkg::*;
#(
    parameter int DW    = 16,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                 clk,
    input  logic                 rst_n,
    median_filter_3x3_if.slave   bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, pc;
    logic [RW-1:0] row_q, row_d, pr;
    logic          acc;
    logic          frame_err_q, frame_err_d;

    logic [DW-1:0] lb0_mem [IMG_W];   // row r-1
    logic [DW-1:0] lb1_mem [IMG_W];   // row r-2
    logic [DW-1:0] lb0_rd, lb1_rd;

    // win_q[row][col]: row 0 oldest line, col 2 newest column.
    logic [2:0][2:0][DW-1:0] win_q, win_d;
    logic                    win_vld_q, win_vld_d, win_sof;
    logic [PIPE_LAT:0]       sof_pipe_q, sof_pipe_d;

    logic [2:0]              s1_vld_v;
    logic                    s1_vld;
    logic [2:0][DW-1:0]      s1_lo, s1_mid, s1_hi;

    logic                    s2_vld_q, s2_vld_d;
    logic [DW-1:0]           s2_maxlo_q, s2_medmid_q, s2_minhi_q, s2_minlo_q, s2_maxhi_q;
    logic [DW-1:0]           s2_maxlo_d, s2_medmid_d, s2_minhi_d, s2_minlo_d, s2_maxhi_d;

    logic                    s3_vld;
    logic [DW-1:0]           s3_lo, s3_mid, s3_hi;
    logic [DW-1:0]           out_min_q, out_min_d, out_max_q, out_max_d;
    logic                    unused_s3;

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return lt(CMP_W'(x), CMP_W'(y), DW) ? x : y;
    endfunction

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return lt(CMP_W'(x), CMP_W'(y), DW) ? y : x;
    endfunction

    function automatic logic [DW-1:0] med3(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                           input logic [DW-1:0] z);
        return max2(min2(x, y), min2(max2(x, y), z));
    endfunction

    always_comb begin
        // in_sof always restarts at (0,0), whatever the tracking state.
        acc    = bus.in_valid && (bus.in_sof || state_q == RUN);
        pc     = bus.in_sof ? '0 : col_q;
        pr     = bus.in_sof ? '0 : row_q;
        lb0_rd = lb0_mem[pc];
        lb1_rd = lb1_mem[pc];

        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        frame_err_d = bus.in_valid && bus.in_sof && state_q == RUN;
        win_d       = win_q;
        win_vld_d   = 1'b0;
        win_sof     = 1'b0;

        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = bus.in_data;
            // Requiring c>=2 keeps all three columns on the same lines.
            win_vld_d   = (pr >= RW'(2)) && (pc >= CW'(2));
            win_sof     = (pr == RW'(2)) && (pc == CW'(2));

            if (pc == CW'(IMG_W - 1)) begin
                col_d = '0;
                if (pr == RW'(IMG_H - 1)) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d   = pr + RW'(1);
                    state_d = RUN;
                end
            end else begin
                col_d   = pc + CW'(1);
                row_d   = pr;
                state_d = RUN;
            end
        end

        sof_pipe_d = {sof_pipe_q[PIPE_LAT-1:0], win_sof};

        // S2: median of nine = med3(max of lows, median of mids, min of highs).
        s2_vld_d    = s1_vld;
        s2_maxlo_d  = s2_maxlo_q;
        s2_medmid_d = s2_medmid_q;
        s2_minhi_d  = s2_minhi_q;
        s2_minlo_d  = s2_minlo_q;
        s2_maxhi_d  = s2_maxhi_q;
        if (s1_vld) begin
            s2_maxlo_d  = max2(max2(s1_lo[0], s1_lo[1]), s1_lo[2]);
            s2_medmid_d = med3(s1_mid[0], s1_mid[1], s1_mid[2]);
            s2_minhi_d  = min2(min2(s1_hi[0], s1_hi[1]), s1_hi[2]);
            s2_minlo_d  = min2(min2(s1_lo[0], s1_lo[1]), s1_lo[2]);
            s2_maxhi_d  = max2(max2(s1_hi[0], s1_hi[1]), s1_hi[2]);
        end

        out_min_d = s2_vld_q ? s2_minlo_q : out_min_q;
        out_max_d = s2_vld_q ? s2_maxhi_q : out_max_q;
    end

    // Line buffers are never reset; every location is rewritten before use.
    // The comb read above sees the old word, giving read-before-write.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_mem[pc] <= lb0_rd;
            lb0_mem[pc] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            frame_err_q <= 1'b0;
            win_q       <= '0;
            win_vld_q   <= 1'b0;
            sof_pipe_q  <= '0;
            s2_vld_q    <= 1'b0;
            s2_maxlo_q  <= '0;
            s2_medmid_q <= '0;
            s2_minhi_q  <= '0;
            s2_minlo_q  <= '0;
            s2_maxhi_q  <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_err_q <= frame_err_d;
            win_q       <= win_d;
            win_vld_q   <= win_vld_d;
            sof_pipe_q  <= sof_pipe_d;
            s2_vld_q    <= s2_vld_d;
            s2_maxlo_q  <= s2_maxlo_d;
            s2_medmid_q <= s2_medmid_d;
            s2_minhi_q  <= s2_minhi_d;
            s2_minlo_q  <= s2_minlo_d;
            s2_maxhi_q  <= s2_maxhi_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
        end
    end

    // S1: sort each window column.
    for (genvar j = 0; j < 3; j++) begin : g_s1
        sort3_stage #(.DW(DW)) u_sort (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_vld  (win_vld_q),
            .a       (win_q[0][j]),
            .b       (win_q[1][j]),
            .c       (win_q[2][j]),
            .out_vld (s1_vld_v[j]),
            .lo      (s1_lo[j]),
            .mid     (s1_mid[j]),
            .hi      (s1_hi[j])
        );
    end
    assign s1_vld = &s1_vld_v;

    // S3: the median of the three S2 terms is the middle of a 3-sort.
    sort3_stage #(.DW(DW)) u_s3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (s2_vld_q),
        .a       (s2_maxlo_q),
        .b       (s2_medmid_q),
        .c       (s2_minhi_q),
        .out_vld (s3_vld),
        .lo      (s3_lo),
        .mid     (s3_mid),
        .hi      (s3_hi)
    );
    // Only the middle value of S3 is needed.
    assign unused_s3 = ^{s3_lo, s3_hi};

    assign bus.out_valid = s3_vld;
    assign bus.out_sof   = sof_pipe_q[PIPE_LAT];
    assign bus.out_med   = s3_mid;
    assign bus.out_min   = out_min_q;
    assign bus.out_max   = out_max_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_median_filter_3x3.sv
// -----------------------------------------------------------------------------
// tb_median_filter_3x3
// Scoreboard bench for median_filter_3x3 on a 4x4 image. The driver feeds a
// frame-tracking reference model that stores pixels in an image array and, for
// every complete window, sorts the nine values to get median/min/max. Expected
// results (with due cycle) go into a queue; a negedge monitor pops and compares.
// Build option: MEDIAN_FILTER_SIGNED_EN switches the model to signed values.
// -----------------------------------------------------------------------------
module tb_median_filter_3x3;
    import median_filter_pkg::*;

    localparam int DW    = 16;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;

    typedef struct {
        logic [DW-1:0] med;
        logic [DW-1:0] mn;
        logic [DW-1:0] mx;
        logic          sof;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;

    exp_t          exp_q[$];
    int            err_q[$];
    logic [DW-1:0] obs_med[$];
    logic [DW-1:0] obs_min[$];
    logic [DW-1:0] obs_max[$];
    logic          obs_sof[$];

    logic [DW-1:0] img [IMG_H][IMG_W];
    bit            m_run = 1'b0;
    int            m_col = 0;
    int            m_row = 0;

    median_filter_3x3_if #(.DW(DW)) bus ();

    median_filter_3x3 #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int to_int(input logic [DW-1:0] v);
`ifdef MEDIAN_FILTER_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    // Reference: position tracking and window statistics straight from the rules.
    task automatic model(input logic sof, input logic [DW-1:0] d);
        int   pc, pr, t;
        bit   take;
        int   q[$];
        exp_t e;
        take = 1'b0;
        pc = 0;
        pr = 0;
        if (sof) begin
            if (m_run) err_q.push_back(cyc + 1);
            take = 1'b1;
        end else if (m_run) begin
            pc = m_col;
            pr = m_row;
            take = 1'b1;
        end
        if (!take) return;
        img[pr][pc] = d;
        if (pr >= 2 && pc >= 2) begin
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    q.push_back(to_int(img[pr-2+dr][pc-2+dc]));
            q.sort();
            t = q[4]; e.med = t[DW-1:0];
            t = q[0]; e.mn  = t[DW-1:0];
            t = q[8]; e.mx  = t[DW-1:0];
            e.sof = (pr == 2 && pc == 2);
            e.due = cyc + 4;
            exp_q.push_back(e);
        end
        if (pc == IMG_W - 1) begin
            m_col = 0;
            if (pr == IMG_H - 1) begin m_row = 0; m_run = 1'b0; end
            else begin m_row = pr + 1; m_run = 1'b1; end
        end else begin
            m_col = pc + 1;
            m_row = pr;
            m_run = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL missing_result due %0d now %0d", exp_q[0].due, cyc);
            void'(exp_q.pop_front());
        end
        while (err_q.size() > 0 && err_q[0] < cyc) begin
            checks++; errors++;
            $display("FAIL missing_frame_err due %0d now %0d", err_q[0], cyc);
            void'(err_q.pop_front());
        end
        if (bus.frame_err) begin
            checks++;
            err_seen++;
            if (err_q.size() > 0 && err_q[0] == cyc) void'(err_q.pop_front());
            else begin
                errors++;
                $display("FAIL unexpected_frame_err at cycle %0d", cyc);
            end
        end
        if (bus.out_valid) begin
            exp_t e;
            checks++;
            obs_med.push_back(bus.out_med);
            obs_min.push_back(bus.out_min);
            obs_max.push_back(bus.out_max);
            obs_sof.push_back(bus.out_sof);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid at cycle %0d med %0h", cyc, bus.out_med);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_med !== e.med || bus.out_min !== e.mn || bus.out_max !== e.mx ||
                    bus.out_sof !== e.sof || cyc != e.due) begin
                    errors++;
                    $display("FAIL result got med %0h min %0h max %0h sof %0b cyc %0d expected med %0h min %0h max %0h sof %0b cyc %0d",
                             bus.out_med, bus.out_min, bus.out_max, bus.out_sof, cyc,
                             e.med, e.mn, e.mx, e.sof, e.due);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic beat(input logic sof, input logic [DW-1:0] d);
        @(negedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        model(sof, d);
    endtask

    // Idle cycles carry junk on in_sof/in_data to check in_valid qualification.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'($urandom_range(0, 1));
            bus.in_data  = DW'($urandom);
        end
    endtask

    // kind: 0 ramp 1..16, 1 impulse, 2 ramp -8..7, 3 random, 4 small random (ties)
    task automatic send_frame(input int kind, input int gap);
        logic [DW-1:0] d;
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            case (kind)
                0:       d = DW'(i + 1);
                1:       d = (i == 5) ? DW'(4095) : DW'(100);
                2:       d = DW'(i - 8);
                3:       d = DW'($urandom);
                default: d = DW'($urandom_range(0, 3));
            endcase
            beat(i == 0, d);
            if (gap < 0) idle($urandom_range(0, 2));
            else if (gap > 0) idle(gap);
        end
        idle(1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() + err_q.size()) != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size() + err_q.size(), 0);
        idle(3);
    endtask

    task automatic clear_obs();
        obs_med.delete(); obs_min.delete(); obs_max.delete(); obs_sof.delete();
    endtask

    task automatic check_set(input string nm, input int em[4], input int emn[4], input int emx[4]);
        chk({nm, " count"}, obs_med.size(), 4);
        for (int i = 0; i < 4 && i < obs_med.size(); i++) begin
            chk($sformatf("%s med%0d", nm, i), int'(obs_med[i]), em[i]);
            chk($sformatf("%s min%0d", nm, i), int'(obs_min[i]), emn[i]);
            chk($sformatf("%s max%0d", nm, i), int'(obs_max[i]), emx[i]);
            chk($sformatf("%s sof%0d", nm, i), int'(obs_sof[i]), (i == 0) ? 1 : 0);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk); #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        exp_q.delete();
        err_q.delete();
        m_run = 1'b0; m_col = 0; m_row = 0;
        repeat (n) @(negedge clk);
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst out_sof",   int'(bus.out_sof), 0);
        chk("rst out_med",   int'(bus.out_med), 0);
        chk("rst out_min",   int'(bus.out_min), 0);
        chk("rst out_max",   int'(bus.out_max), 0);
        chk("rst frame_err", int'(bus.frame_err), 0);
        #1 rst_n = 1'b1;
    endtask

    int r_med[4] = '{6, 7, 10, 11};
    int r_min[4] = '{1, 2, 5, 6};
    int r_max[4] = '{11, 12, 15, 16};
    int i_med[4] = '{100, 100, 100, 100};
    int i_max[4] = '{4095, 4095, 4095, 4095};
`ifdef MEDIAN_FILTER_SIGNED_EN
    int s_med[4] = '{'hFFFD, 'hFFFE, 1, 2};
    int s_min[4] = '{'hFFF8, 'hFFF9, 'hFFFC, 'hFFFD};
    int s_max[4] = '{2, 3, 6, 7};
`endif

    initial begin
        int e0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        do_reset(3);

        // Ramp, continuous
        clear_obs();
        send_frame(0, 0);
        drain();
        check_set("ramp", r_med, r_min, r_max);

        // Single impulse
        clear_obs();
        send_frame(1, 0);
        drain();
        check_set("impulse", i_med, i_med, i_max);

        // Ramp, valid every other cycle
        clear_obs();
        send_frame(0, 1);
        drain();
        check_set("ramp_gap", r_med, r_min, r_max);

        // in_sof at the 7th pixel of a frame
        clear_obs();
        e0 = err_seen;
        for (int i = 0; i < 6; i++) beat(i == 0, DW'(i + 1));
        send_frame(0, 0);
        drain();
        chk("sof_mid frame_err pulses", err_seen - e0, 1);
        check_set("sof_mid", r_med, r_min, r_max);

        // Reset mid-frame with one result in flight, then beats without in_sof
        clear_obs();
        for (int i = 0; i < 11; i++) beat(i == 0, DW'(i + 1));
        do_reset(1);
        for (int i = 0; i < 5; i++) beat(1'b0, DW'($urandom));
        idle(6);
        chk("post_reset no out_valid", obs_med.size(), 0);
        send_frame(0, 0);
        drain();
        check_set("post_reset", r_med, r_min, r_max);

        // Signed pattern -8..7
        clear_obs();
        send_frame(2, 0);
        drain();
`ifdef MEDIAN_FILTER_SIGNED_EN
        check_set("signed", s_med, s_min, s_max);
`else
        chk("unsigned count", obs_med.size(), 4);
`endif

        // Random frames with random gaps
        for (int f = 0; f < 4; f++) begin
            send_frame((f % 2 == 0) ? 3 : 4, -1);
            if ($urandom_range(0, 1) == 1) idle(2);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/median_filter_3x3.md
Name: median_filter_3x3

Overview:
Streaming 3x3 rank-order filter for raster pixel data, one pixel per accepted beat. Buffers two lines internally and builds a sliding 3x3 window. Emits window median, minimum and maximum through a fixed 3-stage compare pipeline. Sits in the image pre-processing path, ahead of edge and threshold blocks, for impulse-noise removal.

Parameters:
DW, 16, pixel width in bits (>=2)
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  in_data/in_sof are sampled on this edge
in_sof  in  1  first pixel of frame, qualified by in_valid
in_data  in  DW  pixel, raster order
out_valid  out  1  one-cycle pulse per interior window result
out_sof  out  1  high with first out_valid of a frame
out_med  out  DW  window median
out_min  out  DW  window minimum
out_max  out  DW  window maximum
frame_err  out  1  one-cycle pulse on in_sof mid-frame

Behaviour:
- Reset (rst_n low at edge): all outputs 0, state IDLE, col/row counters 0, pipeline valid bits 0. Line-buffer RAM is not reset. Its contents are never used before being rewritten.
- States:
  - IDLE: ignore in_valid beats without in_sof. in_valid&in_sof accepts the beat as pixel (0,0) -> RUN.
  - RUN: each in_valid beat advances col. col wraps IMG_W-1 -> 0 with row+1. Accepting (IMG_W-1, IMG_H-1) -> IDLE, counters 0.
  - RUN with in_valid&in_sof: frame_err=1 for one cycle. The beat is taken as pixel (0,0) of a new frame. Stay in RUN.
- Line buffers:
  - Two RAMs, depth IMG_W, width DW.
  - On an accepted beat at column c: read lb0[c] (row r-1) and lb1[c] (row r-2). Write lb1[c]=old lb0[c] and lb0[c]=in_data.
  - Read-before-write within the same beat.
- Window: 3x3 register array; shifts one column on each accepted beat only. It is complete when the accepted pixel has r>=2 and c>=2; the centre is (r-1, c-1). Window columns never straddle lines, because completion requires c>=2.
- Pipeline: advances every clock with a valid bit per stage; no stalls, no backpressure.
  - S1: sort each window column into lo/mid/hi.
  - S2: compute max(lo), mid(mid), min(hi), min(lo), max(hi).
  - S3: median of the three S2 terms.
- Latency: completing pixel sampled at edge k; out_* registered at edge k+3.
- Outputs:
  - out_min and out_max are delayed to align with out_med.
  - out_valid and out_sof deassert the following cycle; data outputs hold their last value.
- Output count: exactly (IMG_W-2)*(IMG_H-2) out_valid pulses per complete frame. out_sof accompanies the window centred at (1,1).
- Comparisons are unsigned by default. Ties need no ordering rule, because equal values give the same result.
- Gaps in in_valid of any length do not change results, only timing.
- New frame or reset mid-frame: in-flight pipeline results from the old frame still emerge, unless rst_n is asserted. Reset flushes them.

Optional Feature:
- Macro: MEDIAN_FILTER_SIGNED_EN.
- Defined: in_data and outputs are two's complement; every comparator is signed.
- Undefined: all compares are unsigned.
- Datapath widths, latency and ports are identical in both builds.

Decomposition:
- Package median_filter_pkg: state typedef (IDLE, RUN), constant PIPE_LAT=3, and a compare function (lt) whose signedness is selected by the macro.
- Sub-module sort3_stage: registered 3-input sorter (lo/mid/hi outputs plus a pass-through valid bit). Three instances serve S1. The S3 median reuses the same sort logic.
- Line-buffer RAMs are inferred in the top module.

Test Plan:
- IMG_W=IMG_H=4, frame pixels 1..16, in_valid continuous:
  - out_med 6,7,10,11; out_min 1,2,5,6; out_max 11,12,15,16.
  - out_sof with the first result only.
  - First out_valid 3 edges after pixel 11 is sampled.
- 4x4 frame, all pixels 100 except 4095 at (1,1):
  - Four results, out_med=100 for all four.
  - out_max=4095 for all four; out_min=100.
- Test-1 frame with in_valid high every other cycle: identical values; each result 3 edges after its completing pixel.
- in_sof at the 7th pixel of a frame:
  - frame_err pulses once; counters restart.
  - The following complete 16-pixel frame reproduces test-1 values with no extra out_valid pulses.
- rst_n low for one cycle mid-frame:
  - All outputs 0 at the next edge.
  - Subsequent beats without in_sof give no out_valid.
  - After a fresh in_sof frame, test-1 values.
- With MEDIAN_FILTER_SIGNED_EN, DW=16, 4x4 frame of -8..7 raster:
  - out_med -3,-2,1,2; out_min -8,-7,-4,-3.
  - Without the macro, the same bit patterns sort as unsigned and the results differ.
